// File: rtl/multiword_add_ctrl.sv
// Nibble-serial adder/subtractor: one 4-bit ripple slice is reused over NIBBLES
// clocks, LSB nibble first. Go/Ack handshake via IDLE/RUN/DONE.
//
// state | meaning
// IDLE  | ready for a new operation, waiting for go
// RUN   | one nibble processed per clock, k = nibble index
// DONE  | result valid, held until ack
module multiword_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   go,
    input  logic                   sub,
    input  logic                   cin,
    input  logic [4*NIBBLES-1:0]   x,
    input  logic [4*NIBBLES-1:0]   y,
    input  logic                   ack,
    output logic                   ready,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   s,
    output logic                   cout,
    output logic                   ovf
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [2:0] KLAST = 3'(NIBBLES - 1);

    state_t               state, state_nxt;
    logic [4*NIBBLES-1:0] xr, yr;
    logic                 subr;
    logic                 carry;
    logic [2:0]           k;

    logic [3:0] nib_a, nib_b, nib_sum;
    logic [4:0] c;

    // Single shared 4-bit ripple slice; c[3] is kept for overflow detection
    always_comb begin
        nib_a = 4'(xr >> {k, 2'b00});
        nib_b = 4'(yr >> {k, 2'b00}) ^ {4{subr}};
        c     = '0;
        c[0]  = carry;
        nib_sum = '0;
        for (int i = 0; i < 4; i++) begin
            nib_sum[i] = nib_a[i] ^ nib_b[i] ^ c[i];
            c[i+1]     = (nib_a[i] & nib_b[i]) | (c[i] & (nib_a[i] ^ nib_b[i]));
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (go) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (k == KLAST) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            xr    <= '0;
            yr    <= '0;
            subr  <= 1'b0;
            carry <= 1'b0;
            k     <= '0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (go) begin
                        xr    <= x;
                        yr    <= y;
                        subr  <= sub;
                        carry <= sub ? 1'b1 : cin;
                        k     <= '0;
                    end
                end
                RUN: begin
                    s[{k, 2'b00} +: 4] <= nib_sum;
                    carry <= c[4];
                    if (k == KLAST) begin
                        k    <= '0;
                        cout <= c[4];
                        ovf  <= c[3] ^ c[4];
                    end else begin
                        k <= k + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/multiword_add_ctrl.md
MULTIWORD_ADD_CTRL -- requirements
Module: multiword_add_ctrl

Interface
REQ-001 The module SHALL have parameter NIBBLES, default 4, giving the operand width in 4-bit digits (W = 4*NIBBLES, legal range 2..8).
REQ-002 The module SHALL have one clock and a synchronous, active-high reset, named as follows.
REQ-003 Clock  input  1  rising-edge clock for all state.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Go  input  1  request to start an operation; valid only while Ready=1.
REQ-006 Sub  input  1  operation select: 0 = X+Y+Cin, 1 = X-Y; sampled at acceptance.
REQ-007 Cin  input  1  carry-in for add mode; sampled at acceptance.
REQ-008 X, Y  input  W  operands; sampled at acceptance.
REQ-009 Ack  input  1  consumer acknowledge of the result.
REQ-010 Ready  output  1  high in IDLE only.
REQ-011 Busy  output  1  high in RUN only.
REQ-012 Done  output  1  high in DONE only.
REQ-013 S  output  W  result.
REQ-014 Cout  output  1  final carry (add); no-borrow flag (sub).
REQ-015 Ovf  output  1  two's-complement overflow.

Function
REQ-016 The block SHALL compute the W-bit result with exactly one 4-bit ripple adder slice (Cin, X[3:0], Y[3:0] -> S[3:0], Cout), one nibble per clock, least significant nibble first.
REQ-017 The FSM SHALL have states IDLE, RUN and DONE; no other reachable states.
REQ-018 Acceptance SHALL be the rising edge on which state=IDLE and Go=1; it latches X, Y, Sub, Cin, sets nibble index k=0 and enters RUN.
REQ-019 Go outside IDLE SHALL be ignored, and X, Y, Sub, Cin changes after acceptance SHALL not affect the result.
REQ-020 On each RUN edge the slice SHALL add latched X nibble k and the latched Y nibble k (inverted when Sub=1), plus the carry register, write S[4k+3:4k], update the carry register from slice Cout, and increment k.
REQ-021 The initial carry register SHALL be Cin when Sub=0 and 1 when Sub=1 (Cin ignored).
REQ-022 The RUN-to-DONE transition SHALL occur on the edge that processes nibble NIBBLES-1; Done is high exactly NIBBLES cycles after the acceptance edge.
REQ-023 At entry to DONE: Cout = final carry; Ovf = carry into bit W-1 XOR carry out of bit W-1.
REQ-024 S, Cout and Ovf SHALL be valid only while Done=1.
REQ-025 In DONE, Ack=1 SHALL return the FSM to IDLE on the next edge; S, Cout and Ovf hold their values until the next acceptance.
REQ-026 Ack outside DONE SHALL be ignored, and DONE SHALL persist indefinitely without Ack.
REQ-027 A new operation SHALL be accepted no earlier than one cycle after the Ack edge (no Go/Ack overlap path).
REQ-028 Intermediate S nibbles SHALL update during RUN; no glitch-free guarantee applies before Done.

Reset
REQ-029 Reset=1 on a rising edge SHALL force IDLE from any state, including mid-RUN; Ready=1, Busy=0, Done=0, S=0, Cout=0, Ovf=0, and carry register and k = 0.
REQ-030 Reset SHALL take priority over Go and Ack on the same edge.

Verification
REQ-031 Add, NIBBLES=4: X=0x1234, Y=0x4321, Cin=0, Sub=0 -> after 4 cycles, Done=1, S=0x5555, Cout=0, Ovf=0.
REQ-032 Wrap-around: X=0xFFFF, Y=0x0001, Cin=0 -> S=0x0000, Cout=1, Ovf=0; X=0x7FFF, Y=0x0001 -> S=0x8000, Cout=0, Ovf=1.
REQ-033 Subtract: X=0x0005, Y=0x0007, Sub=1, Cin=1 (ignored) -> S=0xFFFE, Cout=0, Ovf=0; X=0x8000, Y=0x0001 -> S=0x7FFF, Cout=1, Ovf=1.
REQ-034 Busy protection: Go pulsed and X/Y changed during RUN -> no restart, result matches originally latched operands, Done timing unchanged.
REQ-035 Reset mid-RUN at k=2 -> next cycle Ready=1, all outputs 0; a fresh 0x0001+0x0001 then yields S=0x0002 in 4 cycles.
REQ-036 Handshake: Done held 10 cycles with Ack=0 -> S stable; Ack=1 -> IDLE next edge, S retained, Ready=1.
